// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small transmit FIFO.
// Frames are start, DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS stop bits.
module uart_tx_cfg #(
    parameter int unsigned CLK_DIV    = 286,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_BITS-1:0]               data,
    input  logic                               data_valid,
    output logic                               data_ready,
    output logic                               tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CLK_DIV);

    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("uart_tx_cfg: CLK_DIV must be 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..8");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of two in 2..16");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          baud_q;
    logic [2:0]             bit_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   par_q;
    logic                   tx_q;

    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [LW-1:0]          level_q;
    logic [LW-1:0]          level_d;

    logic                   push;
    logic                   pop;
    logic                   baud_wrap;
    logic                   stop_last;
    logic [DATA_BITS-1:0]   head;
    logic                   head_par;

    assign data_ready = (level_q < LW'(FIFO_DEPTH));
    assign push       = data_valid && data_ready;
    assign baud_wrap  = (baud_q == CW'(CLK_DIV - 1));
    assign stop_last  = (state_q == S_STOP) && baud_wrap && (bit_q == 3'(STOP_BITS - 1));
    // A pop happens when idle or at the very end of a frame, so frames run back-to-back.
    assign pop        = (level_q != '0) && ((state_q == S_IDLE) || stop_last);
    assign head       = mem_q[rd_ptr_q];
    assign head_par   = (^head) ^ (PARITY == 1);

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            if (state_q != S_IDLE) begin
                baud_q <= baud_wrap ? '0 : baud_q + CW'(1);
            end
            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    if (pop) begin
                        state_q <= S_START;
                        shreg_q <= head;
                        par_q   <= head_par;
                        tx_q    <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_wrap) begin
                        state_q <= S_DATA;
                        bit_q   <= '0;
                        tx_q    <= shreg_q[0];
                    end
                end
                S_DATA: begin
                    if (baud_wrap) begin
                        if (bit_q == 3'(DATA_BITS - 1)) begin
                            bit_q <= '0;
                            if (PARITY != 0) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shreg_q <= shreg_q >> 1;
                            tx_q    <= shreg_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_wrap) begin
                        state_q <= S_STOP;
                        bit_q   <= '0;
                        tx_q    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_wrap) begin
                        if (stop_last) begin
                            bit_q <= '0;
                            if (pop) begin
                                state_q <= S_START;
                                shreg_q <= head;
                                par_q   <= head_par;
                                tx_q    <= 1'b0;
                            end else begin
                                state_q <= S_IDLE;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || (level_q != '0);
    assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a cycle-level frame-timing model checks the main instance,
// and two extra instances get directed frame checks (odd parity, default parameters).
module tb_uart_tx_cfg;

    localparam int CD  = 4;
    localparam int DB  = 7;
    localparam int PAR = 2;
    localparam int SB  = 2;
    localparam int DEP = 4;
    localparam int FL  = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * CD;

    logic          clk;
    logic          rst;

    logic [DB-1:0] m_data;
    logic          m_valid, m_ready, m_tx, m_busy;
    logic [2:0]    m_level;

    logic [7:0]    o_data;
    logic          o_valid, o_ready, o_tx, o_busy;
    logic [1:0]    o_level;

    logic [7:0]    d_data;
    logic          d_valid, d_ready, d_tx, d_busy;
    logic [2:0]    d_level;

    int errors = 0;
    int checks = 0;

    logic [7:0] mq[$];
    logic [7:0] cur = '0;
    int         ft  = -1;

    uart_tx_cfg #(.CLK_DIV(CD), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .data(m_data), .data_valid(m_valid), .data_ready(m_ready),
        .tx(m_tx), .busy(m_busy), .fifo_level(m_level));

    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) dut_odd (
        .clk(clk), .rst(rst), .data(o_data), .data_valid(o_valid), .data_ready(o_ready),
        .tx(o_tx), .busy(o_busy), .fifo_level(o_level));

    uart_tx_cfg dut_def (
        .clk(clk), .rst(rst), .data(d_data), .data_valid(d_valid), .data_ready(d_ready),
        .tx(d_tx), .busy(d_busy), .fifo_level(d_level));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Line level for bit slot idx of a frame carrying w.
    function automatic logic fbit(input logic [7:0] w, input int nb, input int par, input int idx);
        logic p;
        p = 1'b0;
        if (idx == 0) return 1'b0;
        if (idx <= nb) return w[idx-1];
        for (int i = 0; i < nb; i++) p = p ^ w[i];
        if (par != 0 && idx == nb + 1) return (par == 2) ? p : ~p;
        return 1'b1;
    endfunction

    task automatic mstep(input logic r, input logic v, input logic [DB-1:0] d);
        int sz;
        bit acc;
        bit fin;
        rst     = r;
        m_valid = v;
        m_data  = d;
        sz = mq.size();
        if (r) begin
            mq.delete();
            ft = -1;
        end else begin
            acc = v && (sz < DEP);
            fin = (ft == FL - 1);
            if ((ft < 0 || fin) && sz > 0) begin
                cur = mq.pop_front();
                ft  = 0;
            end else if (ft < 0 || fin) begin
                ft = -1;
            end else begin
                ft++;
            end
            if (acc) mq.push_back(8'(d));
        end
        @(posedge clk);
        #1;
        chk("tx",    32'(m_tx),    (ft < 0) ? 32'd1 : 32'(fbit(cur, DB, PAR, ft / CD)));
        chk("busy",  32'(m_busy),  32'((ft >= 0) || (mq.size() > 0)));
        chk("level", 32'(m_level), 32'(mq.size()));
        chk("ready", 32'(m_ready), 32'(mq.size() < DEP));
    endtask

    task automatic run_idle(input int maxc);
        int n;
        n = 0;
        while ((ft >= 0 || mq.size() > 0) && n < maxc) begin
            mstep(1'b0, 1'b0, '0);
            n++;
        end
        chk("idle_busy", 32'(m_busy), 32'd0);
    endtask

    function automatic logic tx_of(input int inst);
        return (inst == 1) ? o_tx : d_tx;
    endfunction

    function automatic logic busy_of(input int inst);
        return (inst == 1) ? o_busy : d_busy;
    endfunction

    // One push into an idle side instance, then a mid-bit sample of every slot and the busy fall edge.
    task automatic frame_check(input int inst, input logic [7:0] w);
        int nb, par, sb, cd, nbits;
        nb = 8; sb = 1;
        par = (inst == 1) ? 1 : 0;
        cd  = (inst == 1) ? 4 : 286;
        nbits = 1 + nb + ((par != 0) ? 1 : 0) + sb;
        if (inst == 1) begin o_data = w; o_valid = 1'b1; end
        else begin d_data = w; d_valid = 1'b1; end
        @(posedge clk);
        #1;
        o_valid = 1'b0;
        d_valid = 1'b0;
        chk("side_tx_push_edge", 32'(tx_of(inst)), 32'd1);
        chk("side_busy_rise", 32'(busy_of(inst)), 32'd1);
        @(posedge clk);
        #1;
        chk("side_start_edge", 32'(tx_of(inst)), 32'd0);
        repeat (cd / 2) @(posedge clk);
        #1;
        for (int b = 0; b < nbits; b++) begin
            chk($sformatf("side%0d_bit%0d", inst, b), 32'(tx_of(inst)), 32'(fbit(w, nb, par, b)));
            if (b < nbits - 1) begin
                repeat (cd) @(posedge clk);
                #1;
            end
        end
        repeat (cd - cd / 2 - 1) @(posedge clk);
        #1;
        chk("side_busy_last", 32'(busy_of(inst)), 32'd1);
        @(posedge clk);
        #1;
        chk("side_busy_fall", 32'(busy_of(inst)), 32'd0);
        chk("side_tx_idle", 32'(tx_of(inst)), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        m_valid = 1'b0; m_data = '0;
        o_valid = 1'b0; o_data = '0;
        d_valid = 1'b0; d_data = '0;

        // Reset, with pushes that must be discarded.
        for (int i = 0; i < 3; i++) mstep(1'b1, 1'b1, 7'($urandom));
        chk("rst_level_odd", 32'(o_level), 32'd0);
        chk("rst_ready_def", 32'(d_ready), 32'd1);
        for (int i = 0; i < 2; i++) mstep(1'b0, 1'b0, '0);

        mstep(1'b0, 1'b1, 7'h41);
        run_idle(100);

        // Full-rate burst, then pushes while full.
        for (int i = 0; i < 8; i++) mstep(1'b0, 1'b1, 7'($urandom));
        for (int i = 0; i < 10; i++) mstep(1'b0, 1'b0, '0);
        mstep(1'b0, 1'b1, 7'($urandom));
        run_idle(500);

        // Reset in the middle of data bit 3, then a clean frame.
        mstep(1'b0, 1'b1, 7'($urandom));
        for (int i = 0; i < 18; i++) mstep(1'b0, 1'b0, '0);
        mstep(1'b1, 1'b0, '0);
        mstep(1'b0, 1'b0, '0);
        mstep(1'b0, 1'b1, 7'($urandom));
        run_idle(100);

        for (int i = 0; i < 400; i++)
            mstep(1'b0, ($urandom % 3) == 0, 7'($urandom));
        run_idle(600);

        for (int i = 0; i < 300; i++)
            mstep(($urandom % 150) == 0, ($urandom % 2) == 0, 7'($urandom));
        run_idle(600);

        rst = 1'b0;
        frame_check(1, 8'h00);
        frame_check(1, 8'hFF);
        frame_check(1, 8'($urandom));
        frame_check(2, 8'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLK_DIV, default 286: clocks per bit period (33 MHz / 286 ≈ 115200 baud); legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..8.
REQ-003 Parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of two, 2..16.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 data  input  DATA_BITS  word to transmit, LSB first.
REQ-009 data_valid  input  1  data is presented this cycle.
REQ-010 data_ready  output  1  FIFO can accept a word this cycle.
REQ-011 tx  output  1  serial line; idle/mark = 1, always driven (no Z).
REQ-012 busy  output  1  frame in progress or FIFO non-empty.
REQ-013 fifo_level  output  clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Function
REQ-014 Write: a word is accepted at a rising edge where data_valid=1 and data_ready=1; otherwise data is ignored (no error flag).
REQ-015 data_ready = (fifo_level < FIFO_DEPTH), combinational from registered level; a push is refused when full even if a pop occurs in the same cycle.
REQ-016 Simultaneous push and pop when not full: level unchanged, both take effect, FIFO order preserved.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP; DATA indexed by a bit counter 0..DATA_BITS-1, STOP by a counter 0..STOP_BITS-1.
REQ-018 IDLE -> START: at the first edge where FSM is IDLE and FIFO non-empty; the head word is popped into a shift register at that edge and tx=0 from that edge.
REQ-019 Latency: a word pushed into an empty FIFO while IDLE at edge N drives tx=0 from edge N+1.
REQ-020 Each bit (start, data, parity, stop) holds tx for exactly CLK_DIV clocks; baud counter restarts at 0 on every START entry and wraps at CLK_DIV-1.
REQ-021 START -> DATA -> PARITY (only if PARITY≠0) -> STOP, transitions on baud-counter wrap.
REQ-022 Parity bit: even = XOR of data bits; odd = inverted XOR.
REQ-023 STOP drives tx=1 for STOP_BITS periods; at the final wrap, go to START with a fresh pop if the FIFO is non-empty (no idle gap), else IDLE.
REQ-024 Frame length = (1+DATA_BITS+(PARITY≠0)+STOP_BITS)*CLK_DIV clocks exactly.
REQ-025 busy = (state≠IDLE) or (fifo_level≠0); busy rises on the edge of the first push and falls on the edge ending the last stop bit.
REQ-026 The word being shifted is unaffected by subsequent pushes or changes on data.
REQ-027 Illegal parameter values are rejected at elaboration.

Reset
REQ-028 With rst=1 at an edge: state=IDLE, FIFO emptied, fifo_level=0, baud and bit counters=0, tx=1, busy=0, data_ready=1; a push in the same cycle as rst is discarded.
REQ-029 Reset mid-frame aborts immediately: tx=1 from that edge; the partial frame is not resumed.

Verification (CLK_DIV=4 unless stated)
REQ-030 Default params, push 0x55 once -> tx=0 from edge N+1, then 1,0,1,0,1,0,1,0, then 1, each held 286 clocks; busy low after 2860 clocks.
REQ-031 DATA_BITS=7, PARITY=2, STOP_BITS=2, push 0x41 -> bits 0,1000001(LSB first),0,1,1; frame 44 clocks.
REQ-032 PARITY=1, push 0x00 -> parity bit 1; push 0xFF -> parity bit 1 (8 ones, odd).
REQ-033 Push 5 words at full rate into FIFO_DEPTH=4 -> data_ready low after 4 accepted (one popped meanwhile permits the 5th per REQ-016 timing); all words sent back-to-back with no idle gap.
REQ-034 Assert rst during DATA bit 3 -> tx=1, fifo_level=0, busy=0 from that edge; next push yields a complete, correct frame.
REQ-035 Push with data_ready=0 (FIFO full) -> word dropped; fifo_level stays 4; transmitted sequence excludes it.
